sram_req_port: RTL and testbench



---
 rtl/sram_req_port_if.sv | 34 +++
 rtl/sram_req_port.sv | 107 ++++++++++
 tb/tb_sram_req_port.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_req_port_if.sv
// Request/response channel bundle between a bus agent and sram_req_port.
//
// Handshake (both channels): a transfer happens on a rising clk edge where
// valid and ready are both high. The sender holds valid and its payload
// stable until the transfer. ready never depends on valid in the same cycle.
interface sram_req_port_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
);
    // Request channel: one read or byte-masked write per transfer.
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [DATA_WIDTH/8-1:0]   req_wem;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;

    // Response channel: read data in issue order.
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_WIDTH-1:0]     rsp_rdata;

    // Agent side: issues requests and consumes responses.
    modport master (
        output req_valid, req_we, req_wem, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // Port side: accepts requests and produces responses.
    modport slave (
        input  req_valid, req_we, req_wem, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_req_port.sv
// Initiator front-end for a byte-masked single-port block RAM. Drives the RAM
// port straight from the request channel, tracks the 1- or 2-cycle read
// latency with a tag shift register, and returns read data through a small
// response FIFO. Requests are credit-gated so the FIFO can never overflow.
module sram_req_port #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pipen,
    sram_req_port_if.slave          bus,
    output logic                    ram_en,
    output logic                    ram_we,
    output logic [DATA_WIDTH/8-1:0] ram_wem,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_din,
    input  logic [DATA_WIDTH-1:0]   ram_dout,
    output logic                    ram_pipen,
    output logic                    busy
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Read tags: bit 0 is one cycle after acceptance, bit 1 two cycles after.
    logic [1:0]            tag_q, tag_d;
    logic                  ram_pipen_q, ram_pipen_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];

    logic [1:0]            inflight;
    logic [CNT_W:0]        credit_used;
    logic                  mode_pend;
    logic                  req_fire;
    logic                  rd_fire;
    logic                  push;
    logic                  pop;

    // Credit check, mode-change stall and the combinational RAM port drive.
    always_comb begin
        inflight      = {1'b0, tag_q[0]} + {1'b0, tag_q[1]};
        credit_used   = {1'b0, count_q} + (CNT_W + 1)'(inflight);
        mode_pend     = (pipen != ram_pipen_q);
        bus.req_ready = !rst && !mode_pend
                        && (credit_used < (CNT_W + 1)'(RSP_DEPTH));
        req_fire      = bus.req_valid && bus.req_ready;
        rd_fire       = req_fire && !bus.req_we;
        ram_en        = req_fire;
        ram_we        = req_fire && bus.req_we;
        ram_wem       = bus.req_wem;
        ram_addr      = bus.req_addr;
        ram_din       = bus.req_wdata;
        ram_pipen     = ram_pipen_q;
    end

    // Tag advance and capture point; in 1-cycle mode a tag retires at stage 1
    // so it is not carried into stage 2 and stops counting as in flight.
    always_comb begin
        tag_d[0]    = rd_fire;
        tag_d[1]    = tag_q[0] && ram_pipen_q;
        push        = ram_pipen_q ? tag_q[1] : tag_q[0];
        // The mode only changes once nothing is in flight, so every read
        // completes under the latency it was issued with.
        ram_pipen_d = (mode_pend && (inflight == 2'd0)) ? pipen : ram_pipen_q;
    end

    // Response FIFO pointers and occupancy; push and pop together leave the
    // count unchanged at any occupancy.
    always_comb begin
        pop           = (count_q != '0) && bus.rsp_ready;
        wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
        bus.rsp_valid = (count_q != '0);
        bus.rsp_rdata = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
        busy          = (inflight != 2'd0) || (count_q != '0);
    end

    // Control state; reset discards in-flight tags so stale reads never push.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q       <= '0;
            ram_pipen_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            tag_q       <= tag_d;
            ram_pipen_q <= ram_pipen_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage; contents are only visible through the count, so no reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= ram_dout;
        end
    end

endmodule

// File: tb/tb_sram_req_port.sv
// Bench for sram_req_port: behavioural byte-masked RAM with 1/2-cycle read
// latency, a reference memory feeding an expected-data queue, and directed
// sequences for reset, latency, credit backpressure, mode switch and reset.
module tb_sram_req_port;

    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic            clk;
    logic            rst;
    logic            pipen;
    logic            ram_en;
    logic            ram_we;
    logic [DW/8-1:0] ram_wem;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_din;
    logic [DW-1:0]   ram_dout;
    logic            ram_pipen;
    logic            busy;

    sram_req_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_req_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .pipen    (pipen),
        .bus      (bus),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_wem  (ram_wem),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .ram_pipen(ram_pipen),
        .busy     (busy)
    );

    // Clock and cycle counter
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: output register, plus one extra stage when pipelined
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic [DW-1:0] dout1 = '0;
    logic [DW-1:0] dout2 = '0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < DW/8; b++)
                    if (ram_wem[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                dout1 <= ram_mem[ram_addr];
            end
        end
        dout2 <= dout1;
    end
    assign ram_dout = ram_pipen ? dout2 : dout1;

    // Checker
    int n_checks = 0;
    int n_pass   = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Scoreboard: reference memory updated on accepted writes, expected
    // read data queued on accepted reads, compared on each response transfer
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_q [$];
    int n_rd_acc = 0;
    int n_rsp    = 0;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                n_rsp++;
                if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
                else check("rsp_data", bus.rsp_rdata, exp_q.pop_front());
            end
            if (bus.req_valid && bus.req_ready) begin
                if (bus.req_we) begin
                    for (int b = 0; b < DW/8; b++)
                        if (bus.req_wem[b]) ref_mem[bus.req_addr][8*b +: 8] = bus.req_wdata[8*b +: 8];
                end else begin
                    exp_q.push_back(ref_mem[bus.req_addr]);
                    n_rd_acc++;
                end
            end
        end
    end

    // Driver tasks: called just after a rising edge, return just after one
    task automatic req_idle();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [DW/8-1:0] wem, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output int acc);
        int n = 0;
        acc = -1;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_wem   = wem;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.req_ready) begin
            acc = cyc;
            check("ram_en", ram_en, 1);
            check("ram_we", ram_we, we);
            check("ram_addr", ram_addr, addr);
            if (we) begin
                check("ram_wem", ram_wem, wem);
                check("ram_din", ram_din, wdata);
            end
        end else begin
            check("req_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic timed_read(input logic [AW-1:0] addr, input int lat, input logic [DW-1:0] exp_data,
                              output int acc);
        int n = 0;
        do_req(1'b0, '0, addr, '0, acc);
        req_idle();
        @(negedge clk);
        while (!bus.rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (bus.rsp_valid) begin
            check("rd_latency", 64'(cyc - acc), 64'(lat));
            check("rd_value", bus.rsp_rdata, exp_data);
        end else begin
            check("rsp_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed sequences
    initial begin
        int acc, acc_b, acc_c, base_rd, base_rsp, n;
        rst           = 1'b1;
        pipen         = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_wem   = '1;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        // Reset values, with a write held on the request channel
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_ram_pipen", ram_pipen, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_idle();
        @(negedge clk);
        check("post_rst_ready", bus.req_ready, 1);
        @(posedge clk);
        #1;

        // Byte-masked write merge, 1-cycle RAM mode
        do_req(1'b1, 4'hF, 11'h10, 32'hAABBCCDD, acc);
        do_req(1'b1, 4'h5, 11'h10, 32'h11223344, acc);
        timed_read(11'h10, 2, 32'hAA22CC44, acc);

        // Idle mode switch to 2-cycle: one stalled cycle
        pipen = 1'b1;
        @(negedge clk);
        check("mode_idle_ready_low", bus.req_ready, 0);
        check("mode_idle_old", ram_pipen, 0);
        @(negedge clk);
        check("mode_idle_new", ram_pipen, 1);
        check("mode_idle_ready_back", bus.req_ready, 1);
        @(posedge clk);
        #1;
        do_req(1'b1, 4'hF, 11'h20, 32'hAABBCCDD, acc);
        do_req(1'b1, 4'h5, 11'h20, 32'h11223344, acc);
        timed_read(11'h20, 3, 32'hAA22CC44, acc);

        // Credit backpressure in 1-cycle mode
        pipen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++)
            do_req(1'b1, 4'hF, 11'(i), {8'(i), 24'($urandom_range(0, 24'hFFFFFF))}, acc);
        req_idle();
        bus.rsp_ready = 1'b0;
        base_rd  = n_rd_acc;
        base_rsp = n_rsp;
        for (int i = 0; i < 4; i++) do_req(1'b0, '0, 11'(i), '0, acc);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 11'd4;
        repeat (3) begin
            @(negedge clk);
            check("credit_stall", bus.req_ready, 0);
        end
        check("credit_accepted", 64'(n_rd_acc - base_rd), 4);
        check("credit_rsp_valid", bus.rsp_valid, 1);
        check("credit_busy", busy, 1);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        for (int i = 4; i < 8; i++) do_req(1'b0, '0, 11'(i), '0, acc);
        req_idle();
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", 64'(exp_q.size()), 0);
        check("drain_busy", busy, 0);
        check("drain_rsp_count", 64'(n_rsp - base_rsp), 8);
        @(posedge clk);
        #1;

        // Mode switch 2-cycle -> 1-cycle with two reads in flight
        pipen = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_req(1'b0, '0, 11'd0, '0, acc);
        do_req(1'b0, '0, 11'd1, '0, acc_b);
        pipen = 1'b0;
        timed_read(11'd2, 2, ref_mem[2], acc_c);
        check("mode_busy_gap", 64'(acc_c - acc_b), 4);
        check("mode_busy_new", ram_pipen, 0);

        // Reset with two reads in flight and two responses queued
        pipen = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_req(1'b0, '0, 11'(i), '0, acc);
        req_idle();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", bus.req_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_rsp_valid", bus.rsp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ram_pipen", ram_pipen, 0);
        repeat (6) begin
            @(negedge clk);
            check("stale_rsp_valid", bus.rsp_valid, 0);
        end
        @(posedge clk);
        #1;
        timed_read(11'd5, 3, ref_mem[5], acc);
        check("final_queue_empty", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
